adder_share_ctrl: RTL
=====================

// Module: adder_share_ctrl
// PURPOSE
//  Shares one external 64-bit ripple-carry adder (RCA64) among NUM_REQ requesters.
//  Round-robin arbitration, valid/ready request and response handshakes.
//  Holds operands stable for SETTLE_CYCLES so the ripple chain settles before the result is captured.
//  Sits between the client blocks and the single RCA64 instance in the datapath.
// PARAMETERS
//  NUM_REQ        4    number of requesters (>=2)
//  WIDTH          64   operand width; must match the RCA64 instance
//  SETTLE_CYCLES  4    clocks operands are held before capture (>=1)
//  ID_W           2    requester-id width = clog2(NUM_REQ)
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous, active-high reset
//  reqValid     in   NUM_REQ         per-requester request valid
//  reqReady     out  NUM_REQ         one-hot grant/accept, high only in IDLE
//  reqA         in   NUM_REQ*WIDTH   operand A; requester i at [i*WIDTH +: WIDTH]
//  reqB         in   NUM_REQ*WIDTH   operand B; same packing as reqA
//  reqCin       in   NUM_REQ         carry-in per requester
//  respValid    out  1               result valid
//  respReady    in   1               result consumed
//  respSum      out  WIDTH           captured sum
//  respCout     out  1               captured carry-out
//  respId       out  ID_W            index of the requester that owns this result
//  addA, addB   out  WIDTH           registered operands to RCA64
//  addCin       out  1               registered carry-in to RCA64
//  addSum       in   WIDTH           RCA64 sum
//  addCout      in   1               RCA64 carry-out
// BEHAVIOUR
//  - One clock; reset is synchronous, active-high.
//  - Reset values:
//    - state=IDLE; rrPtr=0; counter=0.
//    - reqReady=0; respValid=0; respSum=0; respCout=0; respId=0.
//    - addA=0; addB=0; addCin=0.
//  - FSM states: IDLE, SETTLE, RESP.
//  - IDLE:
//    - Grant g is the first i with reqValid[i]=1, searching rrPtr, rrPtr+1, ... (mod NUM_REQ).
//    - reqReady = onehot(g), combinational. reqReady is all 0 when no request is valid.
//    - On an edge with reqValid[g]&reqReady[g]: latch operands of g into addA/addB/addCin, store g.
//    - That edge loads counter=SETTLE_CYCLES-1 and moves to SETTLE.
//  - SETTLE:
//    - reqReady=0; add* registers hold.
//    - If counter==0: capture addSum/addCout into respSum/respCout, set respId=g, respValid=1, go to RESP.
//    - Otherwise decrement counter.
//    - respValid therefore rises exactly SETTLE_CYCLES edges after the accept edge.
//  - RESP:
//    - respValid=1; respSum/respCout/respId/add* are held stable until the handshake.
//    - On respValid&respReady: respValid=0, rrPtr=(g+1) mod NUM_REQ, go to IDLE.
//    - If respReady is held high, respValid is high for exactly 1 cycle.
//  - Throughput: one op per SETTLE_CYCLES+2 cycles at best; IDLE always lasts at least 1 cycle.
//  - Arithmetic: {respCout,respSum} = A+B+Cin taken from RCA64 unmodified; wraps mod 2^WIDTH; no saturation.
//  - Boundary cases:
//    - reqValid drops before grant: no effect.
//    - reqValid changes during SETTLE/RESP: ignored.
//    - Simultaneous requests: rrPtr has highest priority.
//    - rst in any state: state returns to IDLE on that edge, the op is discarded, no respValid.
// STRUCTURE
//  - Shared package/include adder_share_pkg:
//    - State encodings S_IDLE=2'd0, S_SETTLE=2'd1, S_RESP=2'd2.
//    - Default WIDTH.
//  - One sub-module rr_arbiter (NUM_REQ): inputs req, ptr; output one-hot grant plus index.
//  - RCA64 stays outside this block; the bench wires it to the add* ports.
// TESTING (bench instantiates RCA64 + adder_share_ctrl, SETTLE_CYCLES=4)
//  1. Req0: A=45622127699800, B=39879961242700, Cin=0
//     -> respSum=85502088942500, respCout=0, respId=0; respValid exactly 4 edges after accept.
//  2. Req2: A=135792462378801, B=246809823135792, Cin=1
//     -> respSum=382602285514594, respCout=0, respId=2.
//  3. Req1: A=B=64'hFFFF_FFFF_FFFF_FFFF, Cin=0
//     -> respSum=64'hFFFF_FFFF_FFFF_FFFE, respCout=1 (wrap).
//  4. All four requesters valid continuously, respReady=1
//     -> grants in order 0,1,2,3,0; each respId matches its operands; never two reqReady high.
//  5. respReady=0 for 10 cycles in RESP
//     -> respValid and all resp*/add* outputs stable; no new grant; completes on the first respReady=1.
//  6. rst pulsed in SETTLE
//     -> next cycle all outputs at reset values, no respValid; a following req0 is served normally.

Source files
------------

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: state encodings and default width for the shared-adder controller
package adder_share_pkg;
  localparam int DEF_WIDTH = 64;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first valid request at or after ptr, wrapping around
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] cand;
  always_comb begin
    idx = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
    grant = |req ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sharing of one external ripple-carry adder
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       reqValid,
  output logic [NUM_REQ-1:0]       reqReady,
  input  logic [NUM_REQ*WIDTH-1:0] reqA,
  input  logic [NUM_REQ*WIDTH-1:0] reqB,
  input  logic [NUM_REQ-1:0]       reqCin,
  output logic                     respValid,
  input  logic                     respReady,
  output logic [WIDTH-1:0]         respSum,
  output logic                     respCout,
  output logic [ID_W-1:0]          respId,
  output logic [WIDTH-1:0]         addA,
  output logic [WIDTH-1:0]         addB,
  output logic                     addCin,
  input  logic [WIDTH-1:0]         addSum,
  input  logic                     addCout
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state;
  logic [ID_W-1:0] rrPtr, owner, gIdx;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] grant;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) uArb (
    .req(reqValid),
    .ptr(rrPtr),
    .grant(grant),
    .idx(gIdx)
  );
  assign reqReady = (state == S_IDLE && !rst) ? grant : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      rrPtr <= '0;
      owner <= '0;
      cnt <= '0;
      respValid <= 1'b0;
      respSum <= '0;
      respCout <= 1'b0;
      respId <= '0;
      addA <= '0;
      addB <= '0;
      addCin <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|reqReady) begin
          addA <= reqA[gIdx*WIDTH +: WIDTH];
          addB <= reqB[gIdx*WIDTH +: WIDTH];
          addCin <= reqCin[gIdx];
          owner <= gIdx;
          cnt <= CW'(SETTLE_CYCLES - 1);
          state <= S_SETTLE;
        end
        S_SETTLE: if (cnt == '0) begin
          respSum <= addSum;
          respCout <= addCout;
          respId <= owner;
          respValid <= 1'b1;
          state <= S_RESP;
        end else cnt <= cnt - 1'b1;
        S_RESP: if (respReady) begin
          respValid <= 1'b0;
          rrPtr <= owner == ID_W'(NUM_REQ - 1) ? '0 : owner + 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
